// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART constants and receiver state encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchronizer for an asynchronous single-bit input.
// Rev     : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Purpose : 8N1 UART receiver, mid-bit sampling, one-cycle valid/error strobes.
// Rev     : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 104
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      valid_o,
    output logic                      frame_error_o,
    output logic                      busy_o
);

    localparam int                 CNT_W    = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CNT_W-1:0]   HALF     = CNT_W'(CLOCKS_PER_BAUD / 2);
    localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]         IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic                      rx_sync;
    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_error_q, frame_error_d;
    logic                      busy_q, busy_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (rx_i),
        .q_o     (rx_sync)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;
        busy_d        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (!rx_sync) begin
                    cnt_d   = HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rx_sync) begin
                        cnt_d     = BIT_LAST;
                        bit_idx_d = 3'd0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d   = {rx_sync, shreg_q[UART_DATA_BITS-1:1]};
                    cnt_d     = BIT_LAST;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_sync) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            // A held-low break must see the line recover before a new frame can start.
            ST_WAIT_IDLE: begin
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shreg_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign frame_error_o = frame_error_q;
    assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Purpose : Directed self-checking bench for uart_rx at CLOCKS_PER_BAUD=104.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_error_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_e0 = 0;
    bit both_seen = 1'b0;
    int v_cyc[$];
    int v_dat[$];
    int fe_cyc[$];

    uart_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .rx_i          (rx),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .frame_error_o (frame_error_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    // cyc equals k right after active edge k
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(int'(data_o));
        end
        if (frame_error_o) fe_cyc.push_back(cyc);
        if (valid_o && frame_error_o) both_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int vd(input int i);
        if (i < v_dat.size()) return v_dat[i];
        return -1;
    endfunction

    function automatic int vc(input int i);
        if (i < v_cyc.size()) return v_cyc[i];
        return -1;
    endfunction

    function automatic int fc(input int i);
        if (i < fe_cyc.size()) return fe_cyc[i];
        return -1;
    endfunction

    task automatic clear_log();
        v_cyc.delete();
        v_dat.delete();
        fe_cyc.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Bench-side transmitter: always called and returning on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit);
        rx = 1'b0;
        last_e0 = cyc + 1;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop_bit;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (data_o !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++; if (frame_error_o !== 1'b0) begin n_errors++; $display("FAIL reset_ferr: got %b expected 0", frame_error_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_single_frame();
        int e0;
        idle(20);
        clear_log();
        send_byte(8'h41, CPB, 1'b1);
        e0 = last_e0;
        idle(20);
        n_checks++; if (v_dat.size() != 1) begin n_errors++; $display("FAIL single_count: got %0d expected 1", v_dat.size()); end
        n_checks++; if (vd(0) != 32'h41) begin n_errors++; $display("FAIL single_data: got %h expected 41", vd(0)); end
        n_checks++; if (vc(0) != e0 + 991) begin n_errors++; $display("FAIL single_timing: got %0d expected %0d", vc(0), e0 + 991); end
        n_checks++; if (fe_cyc.size() != 0) begin n_errors++; $display("FAIL single_ferr: got %0d expected 0", fe_cyc.size()); end
        n_checks++; if (data_o !== 8'h41) begin n_errors++; $display("FAIL single_hold: got %h expected 41", data_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL single_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int e0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
        idle(20);
        clear_log();
        send_byte(bytes[0], CPB, 1'b1);
        e0 = last_e0;
        send_byte(bytes[1], CPB, 1'b1);
        send_byte(bytes[2], CPB, 1'b1);
        idle(20);
        n_checks++; if (v_dat.size() != 3) begin n_errors++; $display("FAIL b2b_count: got %0d expected 3", v_dat.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (vd(i) != int'(bytes[i])) begin n_errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, vd(i), bytes[i]); end
            n_checks++; if (vc(i) != e0 + 991 + i * 1040) begin n_errors++; $display("FAIL b2b_timing%0d: got %0d expected %0d", i, vc(i), e0 + 991 + i * 1040); end
        end
        n_checks++; if (fe_cyc.size() != 0) begin n_errors++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cyc.size()); end
    endtask

    task automatic test_glitch();
        int e0;
        idle(20);
        clear_log();
        rx = 1'b0;
        e0 = cyc + 1;
        wait_cyc(e0 + 2);
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_e2: got %b expected 0", busy_o); end
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_e3: got %b expected 1", busy_o); end
        wait_cyc(e0 + 19);
        rx = 1'b1;
        wait_cyc(e0 + 55);
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_e55: got %b expected 1", busy_o); end
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_e56: got %b expected 0", busy_o); end
        idle(200);
        n_checks++; if (v_dat.size() + fe_cyc.size() != 0) begin n_errors++; $display("FAIL glitch_pulses: got %0d expected 0", v_dat.size() + fe_cyc.size()); end
        send_byte(8'h33, CPB, 1'b1);
        idle(20);
        n_checks++; if (v_dat.size() != 1 || vd(0) != 32'h33) begin n_errors++; $display("FAIL glitch_next_frame: got count %0d data %h expected 1 frame of 33", v_dat.size(), vd(0)); end
    endtask

    task automatic test_frame_error();
        int e0;
        idle(20);
        clear_log();
        send_byte(8'hA5, CPB, 1'b0);
        e0 = last_e0;
        repeat (3000) @(negedge clk);
        n_checks++; if (fe_cyc.size() != 1) begin n_errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cyc.size()); end
        n_checks++; if (fc(0) != e0 + 991) begin n_errors++; $display("FAIL ferr_timing: got %0d expected %0d", fc(0), e0 + 991); end
        n_checks++; if (v_dat.size() != 0) begin n_errors++; $display("FAIL ferr_valid: got %0d expected 0", v_dat.size()); end
        n_checks++; if (data_o !== 8'h33) begin n_errors++; $display("FAIL ferr_data_hold: got %h expected 33", data_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL ferr_busy_break: got %b expected 1", busy_o); end
        idle(10);
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ferr_busy_release: got %b expected 0", busy_o); end
        idle(100);
        n_checks++; if (fe_cyc.size() != 1 || v_dat.size() != 0) begin n_errors++; $display("FAIL ferr_no_retrigger: got ferr %0d valid %0d expected 1 and 0", fe_cyc.size(), v_dat.size()); end
        send_byte(8'h96, CPB, 1'b1);
        idle(20);
        n_checks++; if (v_dat.size() != 1 || vd(0) != 32'h96) begin n_errors++; $display("FAIL ferr_recover: got count %0d data %h expected 1 frame of 96", v_dat.size(), vd(0)); end
    endtask

    task automatic test_baud_skew();
        int rates [2];
        rates[0] = 100; rates[1] = 108;
        for (int r = 0; r < 2; r++) begin
            idle(50);
            clear_log();
            send_byte(8'hC3, rates[r], 1'b1);
            idle(50);
            n_checks++; if (v_dat.size() != 1 || vd(0) != 32'hC3) begin n_errors++; $display("FAIL skew_%0d: got count %0d data %h expected 1 frame of c3", rates[r], v_dat.size(), vd(0)); end
            n_checks++; if (fe_cyc.size() != 0) begin n_errors++; $display("FAIL skew_ferr_%0d: got %0d expected 0", rates[r], fe_cyc.size()); end
        end
    endtask

    task automatic test_reset_mid_frame();
        idle(20);
        clear_log();
        // 0xF0 keeps the line high from bit 4 on, so the abandoned tail cannot look like a start bit.
        fork
            send_byte(8'hF0, CPB, 1'b1);
            begin
                repeat (560) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                n_checks++; if (data_o !== 8'h00 || valid_o !== 1'b0 || frame_error_o !== 1'b0 || busy_o !== 1'b0)
                begin n_errors++; $display("FAIL midreset_outputs: got data %h valid %b ferr %b busy %b expected 00 0 0 0", data_o, valid_o, frame_error_o, busy_o); end
            end
        join
        idle(200);
        n_checks++; if (v_dat.size() + fe_cyc.size() != 0) begin n_errors++; $display("FAIL midreset_pulses: got %0d expected 0", v_dat.size() + fe_cyc.size()); end
        send_byte(8'h7E, CPB, 1'b1);
        idle(20);
        n_checks++; if (v_dat.size() != 1 || vd(0) != 32'h7E) begin n_errors++; $display("FAIL midreset_next_frame: got count %0d data %h expected 1 frame of 7e", v_dat.size(), vd(0)); end
    endtask

    task automatic test_exclusive();
        n_checks++; if (both_seen !== 1'b0) begin n_errors++; $display("FAIL exclusive_strobes: got %b expected 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_baud_skew();
        test_reset_mid_frame();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
